// File: rtl/mult_div_pkg.sv
// Shared constants and state encoding for the iterative multiply/divide unit.
package mult_div_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned Iter  = DataW;
  // Width of the {hi, lo} result bus.
  localparam int unsigned BusW  = 2 * DataW;
  localparam int unsigned CntW  = $clog2(Iter + 1);

  localparam logic [DataW-1:0] DivZeroQuot = '1;

  typedef enum logic [1:0] {
    MdIdle = 2'd0,
    MdCalc = 2'd1,
    MdFix  = 2'd2,
    MdDone = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and sign fix-up.
module md_negate #(
  parameter int unsigned Width = 32
) (
  input  logic             i_neg,
  input  logic [Width-1:0] i_val,
  output logic [Width-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + Width'(1)) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit sharing one add/subtract datapath.
// Define MULT_DIV_FAST_MULT_EN to replace the iterative multiply with a single-cycle product.
module mult_div_unit
  import mult_div_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_is_div,
  input  logic              i_is_signed,
  input  logic [DataW-1:0]  i_operand_1,
  input  logic [DataW-1:0]  i_operand_2,
  input  logic              i_hold,
  input  logic              i_flush,
  output logic              o_done,
  output logic              o_busy,
  output logic [BusW-1:0]   o_result
);

  localparam int unsigned AluW = DataW + 1;

  md_state_e         r_state, w_state_next;
  logic              r_is_div, r_neg_hi, r_neg_lo;
  logic [DataW-1:0]  r_opnd;
  logic [BusW-1:0]   r_acc, r_result, w_acc_next;
  logic [CntW-1:0]   r_cnt;

  logic              w_s1, w_s2, w_div_zero, w_calc_last, w_ge;
  logic [DataW-1:0]  w_mag1, w_mag2, w_fix_hi, w_fix_lo;
  logic [BusW-1:0]   w_fix_prod, w_fix;
  logic [AluW-1:0]   w_alu_a, w_alu_b, w_alu_sum;

  assign w_s1       = i_is_signed & i_operand_1[DataW-1];
  assign w_s2       = i_is_signed & i_operand_2[DataW-1];
  assign w_div_zero = i_is_div && (i_operand_2 == '0);

  md_negate #(.Width(DataW)) u_abs_1 (.i_neg(w_s1), .i_val(i_operand_1), .o_val(w_mag1));
  md_negate #(.Width(DataW)) u_abs_2 (.i_neg(w_s2), .i_val(i_operand_2), .o_val(w_mag2));

  // Shared adder: multiply adds the multiplicand on the multiplier LSB, divide trial-subtracts
  // the divisor from the partial remainder with the next dividend bit shifted in.
  assign w_alu_a   = r_is_div ? {r_acc[BusW-1:DataW], r_acc[DataW-1]}
                              : {1'b0, r_acc[BusW-1:DataW]};
  assign w_alu_b   = r_is_div ? ~{1'b0, r_opnd}
                              : (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_alu_sum = w_alu_a + w_alu_b + AluW'(r_is_div);
  assign w_ge      = ~w_alu_sum[AluW-1];

  always_comb begin
    w_acc_next = r_acc;
    if (!r_is_div) begin
`ifdef MULT_DIV_FAST_MULT_EN
      w_acc_next = BusW'(r_opnd) * BusW'(r_acc[DataW-1:0]);
`else
      w_acc_next = {w_alu_sum, r_acc[DataW-1:1]};
`endif
    end else if (w_ge) begin
      w_acc_next = {w_alu_sum[DataW-1:0], r_acc[DataW-2:0], 1'b1};
    end else begin
      w_acc_next = {r_acc[BusW-2:0], 1'b0};
    end
  end

`ifdef MULT_DIV_FAST_MULT_EN
  assign w_calc_last = !r_is_div || (r_cnt == CntW'(Iter - 1));
`else
  assign w_calc_last = (r_cnt == CntW'(Iter - 1));
`endif

  md_negate #(.Width(BusW))  u_fix_prod (.i_neg(r_neg_lo), .i_val(r_acc), .o_val(w_fix_prod));
  md_negate #(.Width(DataW)) u_fix_hi (.i_neg(r_neg_hi), .i_val(r_acc[BusW-1:DataW]),
                                       .o_val(w_fix_hi));
  md_negate #(.Width(DataW)) u_fix_lo (.i_neg(r_neg_lo), .i_val(r_acc[DataW-1:0]),
                                       .o_val(w_fix_lo));
  assign w_fix = r_is_div ? {w_fix_hi, w_fix_lo} : w_fix_prod;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= MdIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Divide by zero goes straight to FIX with the fixed result preloaded.
  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = MdIdle;
    end else begin
      unique case (r_state)
        MdIdle: if (i_en) w_state_next = w_div_zero ? MdFix : MdCalc;
        MdCalc: if (w_calc_last) w_state_next = MdFix;
        MdFix:  w_state_next = MdDone;
        MdDone: if (!i_hold) w_state_next = MdIdle;
      endcase
    end
  end

  always_comb begin
    o_done   = (r_state == MdDone);
    o_busy   = (r_state == MdCalc) || (r_state == MdFix);
    o_result = r_result;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_is_div <= 1'b0;
      r_neg_hi <= 1'b0;
      r_neg_lo <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        MdIdle: begin
          if (i_en) begin
            r_is_div <= i_is_div;
            r_cnt    <= '0;
            if (w_div_zero) begin
              r_acc    <= {i_operand_1, DivZeroQuot};
              r_opnd   <= '0;
              r_neg_hi <= 1'b0;
              r_neg_lo <= 1'b0;
            end else if (i_is_div) begin
              r_acc    <= {{DataW{1'b0}}, w_mag1};
              r_opnd   <= w_mag2;
              r_neg_hi <= w_s1;
              r_neg_lo <= w_s1 ^ w_s2;
            end else begin
              r_acc    <= {{DataW{1'b0}}, w_mag2};
              r_opnd   <= w_mag1;
              r_neg_hi <= w_s1 ^ w_s2;
              r_neg_lo <= w_s1 ^ w_s2;
            end
          end
        end
        MdCalc: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CntW'(1);
        end
        MdFix: if (!i_flush) r_result <= w_fix;
        MdDone: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized bench for mult_div_unit with a result scoreboard.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, en, is_div, is_signed, hold, flush;
  logic [31:0] op1, op2;
  logic        done, busy;
  logic [63:0] result;

  int          total = 0;
  int          bad = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  mult_div_unit dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_is_div    (is_div),
    .i_is_signed (is_signed),
    .i_operand_1 (op1),
    .i_operand_2 (op2),
    .i_hold      (hold),
    .i_flush     (flush),
    .o_done      (done),
    .o_busy      (busy),
    .o_result    (result)
  );

  function automatic logic [63:0] model(input bit d, input bit s, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] pa, pb;
    logic signed [31:0] sa, sb, q, r;
    if (d && b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (!d) begin
      if (!s) return {32'h0, a} * {32'h0, b};
      pa = {{32{a[31]}}, a};
      pb = {{32{b[31]}}, b};
      return pa * pb;
    end
    if (!s) return {a % b, a / b};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit d, input bit s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit push);
    is_div    = d;
    is_signed = s;
    op1       = a;
    op2       = b;
    en        = 1'b1;
    if (push) sb_q.push_back(exp);
    step();
    en        = 1'b0;
    op1       = $urandom;
    op2       = $urandom;
    is_div    = 1'($urandom);
    is_signed = 1'($urandom);
  endtask

  task automatic wait_done(input string tag, input int lat, input bit pulse,
                           output int busy_cnt);
    int          n;
    logic [63:0] exp;
    n        = 0;
    busy_cnt = 0;
    while (!done && n < 80) begin
      if (busy) busy_cnt++;
      step();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    if (done) begin
      chk({tag, " sbq"}, 64'(sb_q.size()), 64'd1);
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        chk({tag, " result"}, result, exp);
      end
      if (pulse) begin
        step();
        chk({tag, " pulse"}, 64'(done), 64'd0);
      end
    end
  endtask

  initial begin
    int          bc;
    int          hits;
    bit          d, s;
    logic [31:0] a, b;

    rst = 1'b1; en = 1'b0; is_div = 1'b0; is_signed = 1'b0;
    hold = 1'b0; flush = 1'b0; op1 = '0; op2 = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset done", 64'(done), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset result", result, 64'd0);

    issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    chk("multu busy", 64'(busy), 64'd1);
    wait_done("multu max", 33, 1'b1, bc);
    chk("multu busy cycles", 64'(bc), 64'd33);
    chk("multu busy after", 64'(busy), 64'd0);

    issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
    wait_done("mult -7*3", 33, 1'b1, bc);
    issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    wait_done("div -7/2", 33, 1'b1, bc);

    issue(1'b1, 1'b0, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 1'b1);
    wait_done("divu by 0", 1, 1'b1, bc);
    issue(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 1'b1);
    wait_done("div by 0", 1, 1'b1, bc);
    issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
    wait_done("div ovf", 33, 1'b1, bc);

    // Held completion: done and result must stay put until hold drops.
    hold = 1'b1;
    issue(1'b1, 1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b1);
    wait_done("divu hold", 33, 1'b0, bc);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold done", 64'(done), 64'd1);
      chk("hold result", result, 64'h0000_0002_0000_000E);
    end
    hold = 1'b0;
    step();
    chk("hold release", 64'(done), 64'd0);
    issue(1'b0, 1'b0, 32'd6, 32'd7, 64'd42, 1'b1);
    wait_done("after hold", 33, 1'b1, bc);

    issue(1'b0, 1'b0, 32'd5, 32'd5, 64'd0, 1'b0);
    for (int i = 0; i < 10; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush done", 64'(done), 64'd0);
    chk("flush busy", 64'(busy), 64'd0);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) hits++;
    end
    chk("flush no done", 64'(hits), 64'd0);
    chk("flush result", result, 64'd42);

    issue(1'b1, 1'b0, 32'd1000, 32'd3, 64'd0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst done", 64'(done), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst result", result, 64'd0);

    for (int i = 0; i < 8; i++) begin
      d = i[0];
      s = i[1];
      a = $urandom;
      b = $urandom;
      if (i[2]) b = b >> 20;
      if (b == 32'h0) b = 32'd9;
      if (d && s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd5;
      issue(d, s, a, b, model(d, s, a, b), 1'b1);
      wait_done("random", 33, 1'b1, bc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
